// File: rtl/dff_sipo_deserializer.sv
// dff_sipo_deserializer: assembles strobed serial bits into WIDTH-bit words
// and offers them through a valid/ready holding register with sticky overrun.
module dff_sipo_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_en,
    input  logic                       clear,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_count,
    output logic                       overrun
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic             strobe, complete, load, drop;

    // clear has priority over a coincident strobe, so the bit is discarded
    always_comb begin
        strobe   = din_en && !clear;
        sr_nx    = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
        complete = strobe && (bit_count == CW'(WIDTH-1));
        load     = complete && (state == EMPTY || dout_ready);
        drop     = complete && state == FULL && !dout_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = (state == EMPTY) ? (complete ? FULL : EMPTY)
                                    : ((dout_ready && !complete) ? EMPTY : FULL);
    end

    always_comb begin
        dout_valid = (state == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr        <= '0;
            bit_count <= '0;
            dout      <= '0;
            overrun   <= 1'b0;
        end else begin
            if (clear) begin
                sr        <= '0;
                bit_count <= '0;
            end else if (strobe) begin
                sr        <= sr_nx;
                bit_count <= complete ? '0 : bit_count + CW'(1);
            end
            if (load)
                dout <= sr_nx;
            overrun <= clear ? 1'b0 : (overrun || drop);
        end
    end
endmodule

// File: tb/tb_dff_sipo_deserializer.sv
// tb_dff_sipo_deserializer: directed checks of both bit orders, handshake,
// backpressure/overrun, clear and asynchronous reset.
module tb_dff_sipo_deserializer;
    logic       clk = 1'b0;
    logic       rst, din, din_en, clear, dout_ready;
    logic [7:0] dout, dout_l;
    logic       dout_valid, dout_valid_l, overrun, overrun_l;
    logic [3:0] bit_count, bit_count_l;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    dff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clear(clear),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .bit_count(bit_count), .overrun(overrun)
    );

    dff_sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_en(din_en), .clear(clear),
        .dout(dout_l), .dout_valid(dout_valid_l), .dout_ready(dout_ready),
        .bit_count(bit_count_l), .overrun(overrun_l)
    );

    // all stimulus is applied at negedge; each strobe spans exactly one posedge
    task automatic strobe(input logic b);
        din    = b;
        din_en = 1'b1;
        @(negedge clk);
        din_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) strobe(w[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        din = 0; din_en = 0; clear = 0; dout_ready = 0;
        do_reset();
        n_cmp++;
        if ({dout, dout_valid, bit_count, overrun} !== 14'h0) begin
            n_bad++;
            $display("FAIL reset: dout=%h valid=%b cnt=%0d ovr=%b expected all 0", dout, dout_valid, bit_count, overrun);
        end
    endtask

    task automatic test_msb_first();
        logic [7:0] w = 8'hA5;
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bit_count !== 4'(i)) begin
                n_bad++;
                $display("FAIL msb_count: got %0d expected %0d", bit_count, i);
            end
            strobe(w[7-i]);
        end
        n_cmp++;
        if (dout !== 8'hA5 || dout_valid !== 1'b1 || bit_count !== 4'd0) begin
            n_bad++;
            $display("FAIL msb_word: dout=%h valid=%b cnt=%0d expected a5 1 0", dout, dout_valid, bit_count);
        end
        @(negedge clk);
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 8'hA5) begin
            n_bad++;
            $display("FAIL msb_accept: valid=%b dout=%h expected 0 a5", dout_valid, dout);
        end
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        send_word(8'hA5);
        n_cmp++;
        if (dout !== 8'hA5 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_first: dout=%h valid=%b ovr=%b expected a5 1 0", dout, dout_valid, overrun);
        end
        send_word(8'h3C);
        n_cmp++;
        if (dout !== 8'hA5 || dout_valid !== 1'b1 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_drop: dout=%h valid=%b ovr=%b expected a5 1 1", dout, dout_valid, overrun);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        n_cmp++;
        if (dout_valid !== 1'b0 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_release: valid=%b ovr=%b expected 0 1", dout_valid, overrun);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_clear_ovr: ovr=%b expected 0", overrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w = 8'hF0;
        dout_ready = 1'b0;
        send_word(8'h0F);
        for (int i = 7; i >= 1; i--) strobe(w[i]);
        n_cmp++;
        if (dout !== 8'h0F || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_hold: dout=%h valid=%b expected 0f 1", dout, dout_valid);
        end
        dout_ready = 1'b1;
        strobe(w[0]);
        n_cmp++;
        if (dout !== 8'hF0 || dout_valid !== 1'b1 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_swap: dout=%h valid=%b ovr=%b expected f0 1 0", dout, dout_valid, overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_clear();
        dout_ready = 1'b1;
        strobe(1); strobe(0); strobe(1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if (bit_count !== 4'd0) begin
            n_bad++;
            $display("FAIL clr_count: got %0d expected 0", bit_count);
        end
        send_word(8'hFF);
        n_cmp++;
        if (dout !== 8'hFF || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_word: dout=%h valid=%b expected ff 1", dout, dout_valid);
        end
        clear = 1'b1;
        strobe(1);
        clear = 1'b0;
        n_cmp++;
        if (bit_count !== 4'd0 || dout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_strobe: cnt=%0d valid=%b expected 0 0", bit_count, dout_valid);
        end
        send_word(8'h81);
        n_cmp++;
        if (dout !== 8'h81 || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_after: dout=%h valid=%b expected 81 1", dout, dout_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        dout_ready = 1'b0;
        send_word(8'h5A);
        strobe(1); strobe(1); strobe(0); strobe(1); strobe(0);
        n_cmp++;
        if (bit_count !== 4'd5 || dout !== 8'h5A || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_pre: cnt=%0d dout=%h valid=%b expected 5 5a 1", bit_count, dout, dout_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({dout, dout_valid, bit_count, overrun} !== 14'h0) begin
            n_bad++;
            $display("FAIL ar_immediate: dout=%h valid=%b cnt=%0d ovr=%b expected all 0", dout, dout_valid, bit_count, overrun);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        dout_ready = 1'b1;
        send_word(8'hC3);
        n_cmp++;
        if (dout !== 8'hC3 || dout_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_after: dout=%h valid=%b expected c3 1", dout, dout_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_lsb_first();
        logic [7:0] bits_a = 8'b1010_0101;
        logic [7:0] bits_b = 8'b1100_0000;
        logic [7:0] gaps   = 8'b0110_1001;
        dout_ready = 1'b1;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            if (gaps[i]) begin
                @(negedge clk);
                @(negedge clk);
            end
            strobe(bits_a[i]);
        end
        n_cmp++;
        if (dout_l !== 8'hA5 || dout_valid_l !== 1'b1) begin
            n_bad++;
            $display("FAIL lsb_a5: dout=%h valid=%b expected a5 1", dout_l, dout_valid_l);
        end
        for (int i = 7; i >= 0; i--) strobe(bits_b[i]);
        n_cmp++;
        if (dout_l !== 8'h03 || dout_valid_l !== 1'b1 || bit_count_l !== 4'd0) begin
            n_bad++;
            $display("FAIL lsb_03: dout=%h valid=%b cnt=%0d expected 03 1 0", dout_l, dout_valid_l, bit_count_l);
        end
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_msb_first();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        test_lsb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
